tl_uh_sram_responder: RTL and testbench

- TileLink Uncached-Heavyweight responder (slave) fronting a single-port on-chip data SRAM.
- Serves the data-cache master: single-beat uncached Get/Put, 128-byte line-fill Get bursts, and back-to-back single-word PutFullData streams from cache-block zeroing.
- One transaction outstanding at a time.
- Sits on the memory side of the dcache A/D channels, or behind an interconnect port.

---
 rtl/tl_pkg.sv | 42 ++++
 rtl/tl_uh_sram_responder_if.sv | 47 ++++
 rtl/tl_resp_sram.sv | 45 ++++
 rtl/tl_uh_sram_responder.sv | 207 ++++++++++++++++++++
 tb/tb_tl_uh_sram_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
//------------------------------------------------------------------------------
// Module   : tl_pkg
// Purpose  : Shared TileLink-UH opcode constants, responder state encoding and
//            the beat-count helper used by the SRAM responder.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PUT_BEATS = 3'd1,
    ST_PUT_ACK   = 3'd2,
    ST_GET_RD    = 3'd3,
    ST_GET_DATA  = 3'd4
  } resp_state_e;

  // Number of 32-bit beats for a given log2 transfer size. Sizes beyond a
  // 32-beat line saturate so the 5-bit beat counter always reaches its end.
  function automatic logic [5:0] beats_from_size(input logic [3:0] size);
    if (size <= 4'd2) begin
      return 6'd1;
    end else if (size >= 4'd7) begin
      return 6'd32;
    end else begin
      return 6'd1 << (size - 4'd2);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_uh_sram_responder_if.sv
//------------------------------------------------------------------------------
// Module   : tl_uh_sram_responder_if
// Purpose  : TileLink-UH A/D channel bundle between the data-cache master and
//            the SRAM responder.
// Ports    : A channel (opcode/param/size/address/mask/data/corrupt/valid in,
//            ready out), D channel (opcode/param/size/denied/data/corrupt/valid
//            out, ready in). Direction suffixes are from the responder's view.
// Modports : master (cache side), slave (responder side)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tl_uh_sram_responder_if;
  logic [2:0]  tl_a_opcode_i;
  logic [2:0]  tl_a_param_i;
  logic [3:0]  tl_a_size_i;
  logic [31:0] tl_a_address_i;
  logic [3:0]  tl_a_mask_i;
  logic [31:0] tl_a_data_i;
  logic        tl_a_corrupt_i;
  logic        tl_a_valid_i;
  logic        tl_a_ready_o;
  logic [2:0]  tl_d_opcode_o;
  logic [1:0]  tl_d_param_o;
  logic [3:0]  tl_d_size_o;
  logic        tl_d_denied_o;
  logic [31:0] tl_d_data_o;
  logic        tl_d_corrupt_o;
  logic        tl_d_valid_o;
  logic        tl_d_ready_i;

  modport master (
    output tl_a_opcode_i, tl_a_param_i, tl_a_size_i, tl_a_address_i,
           tl_a_mask_i, tl_a_data_i, tl_a_corrupt_i, tl_a_valid_i, tl_d_ready_i,
    input  tl_a_ready_o, tl_d_opcode_o, tl_d_param_o, tl_d_size_o,
           tl_d_denied_o, tl_d_data_o, tl_d_corrupt_o, tl_d_valid_o
  );

  modport slave (
    input  tl_a_opcode_i, tl_a_param_i, tl_a_size_i, tl_a_address_i,
           tl_a_mask_i, tl_a_data_i, tl_a_corrupt_i, tl_a_valid_i, tl_d_ready_i,
    output tl_a_ready_o, tl_d_opcode_o, tl_d_param_o, tl_d_size_o,
           tl_d_denied_o, tl_d_data_o, tl_d_corrupt_o, tl_d_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/tl_resp_sram.sv
//------------------------------------------------------------------------------
// Module   : tl_resp_sram
// Purpose  : Single-port synchronous SRAM, 32-bit words, per-byte write
//            enables, output register that only updates on a read enable.
// Ports    : clk, rst_n (async active-low, clears the output register),
//            we[3:0] byte write enables, re read enable, addr word index,
//            wdata write data, rdata registered read data.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tl_resp_sram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we[lane]) begin
        mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  // Output holds its value while re is low so a stalled D beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_uh_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : tl_uh_sram_responder
// Purpose  : TileLink-UH responder in front of a single-port data SRAM. Serves
//            single-beat Get/Put, multi-beat Put streams and line-fill Get
//            bursts, one transaction at a time.
// Ports    : cpu_clock_i clock, cpu_reset_n_i async active-low reset,
//            tl (slave modport) A/D channels.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tl_uh_sram_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MEM_WORDS_LOG2 = 12,
  parameter int          MAX_SIZE       = 7
) (
  input  logic                   cpu_clock_i,
  input  logic                   cpu_reset_n_i,
  tl_uh_sram_responder_if.slave  tl
);

  localparam int          AW           = MEM_WORDS_LOG2;
  localparam logic [3:0]  MAX_SIZE_L   = 4'(MAX_SIZE);
  localparam logic [31:0] REGION_BYTES = 32'd4 << MEM_WORDS_LOG2;

  resp_state_e   state;
  logic [4:0]    cnt;
  logic [4:0]    last;
  logic [AW-1:0] idx;
  logic          denied_q;
  logic          a_ready;
  logic          d_valid;
  logic [2:0]    d_opcode;
  logic [3:0]    d_size;
  logic          d_corrupt;

  logic [3:0]    mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  // Request decode
  logic          a_fire, d_fire;
  logic [31:0]   offset, align_mask;
  logic [AW-1:0] req_idx;
  logic          is_put, is_get, req_denied;
  logic [4:0]    req_last;
  logic [5:0]    req_beats;

  assign a_fire     = tl.tl_a_valid_i & a_ready;
  assign d_fire     = d_valid & tl.tl_d_ready_i;
  assign offset     = tl.tl_a_address_i - BASE_ADDR;
  assign req_idx    = offset[AW+1:2];
  assign align_mask = (32'd1 << tl.tl_a_size_i) - 32'd1;
  assign is_put     = (tl.tl_a_opcode_i == PUT_FULL) || (tl.tl_a_opcode_i == PUT_PARTIAL);
  assign is_get     = (tl.tl_a_opcode_i == GET);
  assign req_denied = !(is_put || is_get)
                    || (tl.tl_a_size_i > MAX_SIZE_L)
                    || ((tl.tl_a_address_i & align_mask) != 32'd0)
                    || (tl.tl_a_address_i < BASE_ADDR)
                    || (offset >= REGION_BYTES);
  assign req_beats  = beats_from_size(tl.tl_a_size_i);
  assign req_last   = 5'(req_beats - 6'd1);

  // SRAM port control
  always_comb begin
    mem_we   = 4'd0;
    mem_re   = 1'b0;
    mem_addr = req_idx;
    case (state)
      ST_IDLE: begin
        if (a_fire && is_put && !req_denied && !tl.tl_a_corrupt_i) begin
          mem_we = tl.tl_a_mask_i;
        end
      end
      ST_PUT_BEATS: begin
        mem_addr = idx + AW'(cnt);
        if (a_fire && !denied_q && !tl.tl_a_corrupt_i) begin
          mem_we = tl.tl_a_mask_i;
        end
      end
      ST_GET_RD: begin
        mem_addr = idx;
        mem_re   = 1'b1;
      end
      ST_GET_DATA: begin
        // Prefetch the next beat as the current one is consumed.
        mem_addr = idx + AW'(cnt + 5'd1);
        mem_re   = d_fire && (cnt != last);
      end
      default: begin
        mem_re = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      state     <= ST_IDLE;
      cnt       <= 5'd0;
      last      <= 5'd0;
      idx       <= '0;
      denied_q  <= 1'b0;
      a_ready   <= 1'b0;
      d_valid   <= 1'b0;
      d_opcode  <= ACCESS_ACK;
      d_size    <= 4'd0;
      d_corrupt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          a_ready <= 1'b1;
          if (a_fire) begin
            idx      <= req_idx;
            denied_q <= req_denied;
            d_size   <= tl.tl_a_size_i;
            last     <= req_last;
            cnt      <= 5'd0;
            if (is_get) begin
              state     <= ST_GET_RD;
              a_ready   <= 1'b0;
              d_opcode  <= ACCESS_ACK_DATA;
              d_corrupt <= req_denied;
            end else if (is_put && (req_last != 5'd0)) begin
              // First beat is written this cycle; later beats start at 1.
              state <= ST_PUT_BEATS;
              cnt   <= 5'd1;
            end else begin
              state     <= ST_PUT_ACK;
              a_ready   <= 1'b0;
              d_valid   <= 1'b1;
              d_opcode  <= ACCESS_ACK;
              d_corrupt <= 1'b0;
            end
          end
        end
        ST_PUT_BEATS: begin
          if (a_fire) begin
            cnt <= cnt + 5'd1;
            if (cnt == last) begin
              state     <= ST_PUT_ACK;
              a_ready   <= 1'b0;
              d_valid   <= 1'b1;
              d_opcode  <= ACCESS_ACK;
              d_corrupt <= 1'b0;
            end
          end
        end
        ST_PUT_ACK: begin
          if (d_fire) begin
            state   <= ST_IDLE;
            d_valid <= 1'b0;
            a_ready <= 1'b1;
          end
        end
        ST_GET_RD: begin
          state   <= ST_GET_DATA;
          d_valid <= 1'b1;
        end
        ST_GET_DATA: begin
          if (d_fire) begin
            if (cnt == last) begin
              state   <= ST_IDLE;
              d_valid <= 1'b0;
              a_ready <= 1'b1;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          d_valid <= 1'b0;
          a_ready <= 1'b0;
        end
      endcase
    end
  end

  tl_resp_sram #(.ADDR_W(AW)) u_sram (
    .clk   (cpu_clock_i),
    .rst_n (cpu_reset_n_i),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (tl.tl_a_data_i),
    .rdata (mem_rdata)
  );

  assign tl.tl_a_ready_o   = a_ready;
  assign tl.tl_d_valid_o   = d_valid;
  assign tl.tl_d_opcode_o  = d_opcode;
  assign tl.tl_d_param_o   = 2'd0;
  assign tl.tl_d_size_o    = d_size;
  assign tl.tl_d_denied_o  = denied_q;
  assign tl.tl_d_corrupt_o = d_corrupt;
  assign tl.tl_d_data_o    = mem_rdata;

  // A param carries no meaning for an uncached responder.
  logic unused_param;
  assign unused_param = ^tl.tl_a_param_i;

endmodule

`default_nettype wire

// File: tb/tb_tl_uh_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_tl_uh_sram_responder
// Purpose  : Self-checking bench for tl_uh_sram_responder: directed cases plus
//            randomized traffic against a word-array reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tl_uh_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          MWL   = 12;
  localparam int          WORDS = 1 << MWL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tl_uh_sram_responder_if bus ();

  tl_uh_sram_responder #(
    .BASE_ADDR      (BASE),
    .MEM_WORDS_LOG2 (MWL),
    .MAX_SIZE       (7)
  ) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_n_i (rst_n),
    .tl            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m   [WORDS];
  bit          written [WORDS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference rules, computed with wide plain arithmetic.
  function automatic bit model_denied(input logic [2:0] op, input logic [3:0] size,
                                      input logic [31:0] addr);
    longint a, lo, hi;
    a  = longint'(addr);
    lo = longint'(BASE);
    hi = lo + (longint'(4) << MWL);
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
    if (size > 4'd7) return 1'b1;
    if ((a % (longint'(1) << size)) != 0) return 1'b1;
    if (a < lo || a >= hi) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_beats(input logic [3:0] size);
    if (size <= 4'd2) return 1;
    return 1 << (size - 4'd2);
  endfunction

  // Present one A beat at a negedge; returns at the negedge after it fires.
  task automatic send_a(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input bit corrupt,
                        input bit keep_valid);
    int cyc;
    bus.tl_a_opcode_i  = op;
    bus.tl_a_param_i   = 3'($urandom_range(0, 7));
    bus.tl_a_size_i    = size;
    bus.tl_a_address_i = addr;
    bus.tl_a_mask_i    = mask;
    bus.tl_a_data_i    = data;
    bus.tl_a_corrupt_i = corrupt;
    bus.tl_a_valid_i   = 1'b1;
    cyc = 0;
    while (!bus.tl_a_ready_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.tl_a_ready_o) chk("a_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (!keep_valid) bus.tl_a_valid_i = 1'b0;
  endtask

  task automatic do_put(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] d0, input bit corrupt);
    bit den;
    int beats, idx, stall;
    logic [31:0] data;
    den   = model_denied(op, size, addr);
    beats = (op == 3'd0 || op == 3'd1) ? model_beats(size) : 1;
    idx   = int'((addr - BASE) >> 2);
    for (int b = 0; b < beats; b++) begin
      data = (b == 0) ? d0 : $urandom;
      send_a(op, size, addr, mask, data, corrupt, b != beats - 1);
      if (!den && !corrupt) begin
        for (int l = 0; l < 4; l++)
          if (mask[l]) mem_m[idx + b][8*l +: 8] = data[8*l +: 8];
        if (mask == 4'hF) written[idx + b] = 1'b1;
      end
    end
    chk("put_ack_valid",  32'(bus.tl_d_valid_o),  32'd1);
    chk("put_ack_opcode", 32'(bus.tl_d_opcode_o), 32'd0);
    chk("put_ack_denied", 32'(bus.tl_d_denied_o), 32'(den));
    chk("put_ack_size",   32'(bus.tl_d_size_o),   32'(size));
    chk("put_ack_aready", 32'(bus.tl_a_ready_o),  32'd0);
    stall = $urandom_range(0, 2);
    bus.tl_d_ready_i = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk("put_ack_hold", 32'(bus.tl_d_valid_o), 32'd1);
    end
    bus.tl_d_ready_i = 1'b1;
    @(negedge clk);
    chk("put_done_dvalid", 32'(bus.tl_d_valid_o), 32'd0);
    chk("put_done_aready", 32'(bus.tl_a_ready_o), 32'd1);
  endtask

  // rmode: 0 d_ready always high, 1 toggling, 2 random. abort_at>=0 asserts
  // reset while that beat is presented and returns with reset still low.
  task automatic do_get(input logic [3:0] size, input logic [31:0] addr,
                        input int rmode, input int abort_at);
    bit den, dr;
    int beats, idx, got, cyc;
    den   = model_denied(3'd4, size, addr);
    beats = model_beats(size);
    idx   = int'((addr - BASE) >> 2);
    send_a(3'd4, size, addr, 4'hF, 32'd0, 1'b0, 1'b0);
    chk("get_latency", 32'(bus.tl_d_valid_o), 32'd0);
    got = 0;
    cyc = 0;
    dr  = 1'b0;
    while (got < beats && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (got == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_dvalid", 32'(bus.tl_d_valid_o), 32'd0);
        chk("reset_aready", 32'(bus.tl_a_ready_o), 32'd0);
        return;
      end
      chk("get_dvalid",  32'(bus.tl_d_valid_o),   32'd1);
      chk("get_opcode",  32'(bus.tl_d_opcode_o),  32'd1);
      chk("get_size",    32'(bus.tl_d_size_o),    32'(size));
      chk("get_denied",  32'(bus.tl_d_denied_o),  32'(den));
      chk("get_corrupt", 32'(bus.tl_d_corrupt_o), 32'(den));
      chk("get_aready",  32'(bus.tl_a_ready_o),   32'd0);
      if (!den && written[idx + got]) chk("get_data", bus.tl_d_data_o, mem_m[idx + got]);
      case (rmode)
        0:       dr = 1'b1;
        1:       dr = ~dr;
        default: dr = 1'($urandom_range(0, 1));
      endcase
      bus.tl_d_ready_i = dr;
      if (dr) got++;
    end
    if (got < beats) chk("get_timeout", 32'(got), 32'(beats));
    if (rmode == 0) chk("get_contiguous", 32'(cyc), 32'(beats));
    @(negedge clk);
    bus.tl_d_ready_i = 1'b1;
    chk("get_done_dvalid", 32'(bus.tl_d_valid_o), 32'd0);
    chk("get_done_aready", 32'(bus.tl_a_ready_o), 32'd1);
  endtask

  initial begin
    int r, sz, w, bts, op;
    logic [31:0] addr;
    bus.tl_a_opcode_i  = 3'd0;
    bus.tl_a_param_i   = 3'd0;
    bus.tl_a_size_i    = 4'd0;
    bus.tl_a_address_i = 32'd0;
    bus.tl_a_mask_i    = 4'd0;
    bus.tl_a_data_i    = 32'd0;
    bus.tl_a_corrupt_i = 1'b0;
    bus.tl_a_valid_i   = 1'b0;
    bus.tl_d_ready_i   = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_aready",  32'(bus.tl_a_ready_o),   32'd0);
    chk("rst_dvalid",  32'(bus.tl_d_valid_o),   32'd0);
    chk("rst_opcode",  32'(bus.tl_d_opcode_o),  32'd0);
    chk("rst_size",    32'(bus.tl_d_size_o),    32'd0);
    chk("rst_denied",  32'(bus.tl_d_denied_o),  32'd0);
    chk("rst_corrupt", 32'(bus.tl_d_corrupt_o), 32'd0);
    chk("rst_data",    bus.tl_d_data_o,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_aready", 32'(bus.tl_a_ready_o), 32'd1);

    // Fill the first 64 words with two 32-beat PutFull streams.
    do_put(3'd0, 4'd7, BASE,          4'hF, $urandom, 1'b0);
    do_put(3'd0, 4'd7, BASE + 32'h80, 4'hF, $urandom, 1'b0);
    do_get(4'd7, BASE, 0, -1);

    // Single word put then get.
    do_put(3'd0, 4'd2, BASE + 32'h40, 4'hF, 32'hDEAD_BEEF, 1'b0);
    do_get(4'd2, BASE + 32'h40, 0, -1);

    // Byte-lane partial write.
    do_put(3'd0, 4'd2, BASE + 32'h40, 4'hF, 32'h1122_3344, 1'b0);
    do_put(3'd1, 4'd0, BASE + 32'h41, 4'b0010, 32'h0000_AB00, 1'b0);
    chk("partial_model", mem_m[16], 32'h1122_AB44);
    do_get(4'd2, BASE + 32'h40, 0, -1);

    // Poisoned beat: acknowledged but not written.
    do_put(3'd0, 4'd2, BASE + 32'h40, 4'hF, 32'hBAD0_BAD0, 1'b1);
    do_get(4'd2, BASE + 32'h40, 0, -1);

    // 32 single-word writes, then line fill with and without backpressure.
    for (int i = 0; i < 32; i++)
      do_put(3'd0, 4'd2, BASE + 32'h80 + 32'(4 * i), 4'hF, 32'(i), 1'b0);
    do_get(4'd7, BASE + 32'h80, 0, -1);
    do_get(4'd7, BASE + 32'h80, 1, -1);

    // Denied requests leave memory intact.
    do_get(4'd2, BASE + (32'd4 << MWL), 0, -1);
    do_get(4'd7, BASE + 32'h84, 0, -1);
    do_put(3'd2, 4'd2, BASE + 32'h80, 4'hF, 32'hFFFF_FFFF, 1'b0);
    do_put(3'd0, 4'd2, BASE + 32'h82, 4'hF, 32'hFFFF_FFFF, 1'b0);
    do_get(4'd7, BASE + 32'h80, 2, -1);

    // Reset in the middle of a burst.
    do_get(4'd7, BASE + 32'h80, 0, 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_aready", 32'(bus.tl_a_ready_o), 32'd1);
    do_get(4'd7, BASE + 32'h80, 0, -1);

    // Randomized traffic within the first 64 words.
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        sz   = $urandom_range(0, 2);
        w    = $urandom_range(0, 63);
        addr = BASE + 32'(4 * w) + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
        do_put(3'($urandom_range(0, 1)), 4'(sz), addr, 4'($urandom_range(0, 15)),
               $urandom, ($urandom_range(0, 7) == 0));
      end else if (r == 4) begin
        sz  = $urandom_range(3, 4);
        bts = 1 << (sz - 2);
        w   = $urandom_range(0, 63) & ~(bts - 1);
        do_put(3'd0, 4'(sz), BASE + 32'(4 * w), 4'hF, $urandom, 1'b0);
      end else if (r <= 8) begin
        sz   = $urandom_range(0, 7);
        bts  = (sz <= 2) ? 1 : (1 << (sz - 2));
        w    = $urandom_range(0, 63) & ~(bts - 1);
        addr = BASE + 32'(4 * w);
        if (sz < 2) addr = addr + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
        do_get(4'(sz), addr, $urandom_range(0, 2), -1);
      end else begin
        op = $urandom_range(0, 1);
        if (op == 0) do_get(4'd2, BASE + 32'(4 * $urandom_range(0, 63)) + 32'd1, 0, -1);
        else do_put(3'(2 + $urandom_range(0, 1) * 4 + $urandom_range(0, 1)), 4'd2,
                    BASE + 32'(4 * $urandom_range(0, 63)), 4'hF, $urandom, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
